// File: rtl/ms_ff_sequencer_if.sv
// Bus between a single requester and the master-slave sequencer: request/data in,
// phase enables, completion pulse and storage contents out.
interface ms_ff_sequencer_if #(
  parameter int WIDTH = 1
);
  logic             req;
  logic [WIDTH-1:0] d;
  logic             ack;
  logic             busy;
  logic             master_en;
  logic             slave_en;
  logic [WIDTH-1:0] mid_q;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  // Handshake: req is a level sampled only while idle; ack is a one-cycle pulse
  // that ends the sequence, busy is high from the first phase through the ack.
  modport master (
    output req, d,
    input  ack, busy, master_en, slave_en, mid_q, q, qbar
  );

  modport slave (
    input  req, d,
    output ack, busy, master_en, slave_en, mid_q, q, qbar
  );
endinterface

// File: rtl/ms_ff_sequencer.sv
// Two-phase non-overlapping sequencer driving a master (mid_q) and slave (q) storage
// stage; all outputs are flops loaded from the next state.
module ms_ff_sequencer #(
  parameter int WIDTH      = 1,
  parameter int MASTER_CYC = 2,
  parameter int SLAVE_CYC  = 2,
  parameter int DEAD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  ms_ff_sequencer_if.slave   bus,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MASTER = 3'd1,
    S_GAP1   = 3'd2,
    S_SLAVE  = 3'd3,
    S_GAP2   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MASTER_CYC - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SLAVE_CYC - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic             NO_GAP = (DEAD_CYC == 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, busy_q, master_en_q, slave_en_q;
  logic [WIDTH-1:0] mid_q_q, q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      master_en_q <= 1'b0;
      slave_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      master_en_q <= (state_d == S_MASTER);
      slave_en_q  <= (state_d == S_SLAVE);
    end
  end

  // Counter is cleared on every transition, so each phase starts counting at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req) state_d = S_MASTER;
      end
      S_MASTER: begin
        if (cnt_q == M_LAST) begin
          state_d = NO_GAP ? S_SLAVE : S_GAP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP1: begin
        if (cnt_q == D_LAST) begin
          state_d = S_SLAVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SLAVE: begin
        if (cnt_q == S_LAST) begin
          state_d = NO_GAP ? S_DONE : S_GAP2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP2: begin
        if (cnt_q == D_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Master tracks d only while its phase is open; slave copies the master only in its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_q_q <= '0;
      q_q     <= '0;
    end else begin
      if (state_q == S_MASTER) mid_q_q <= bus.d;
      if (state_q == S_SLAVE)  q_q     <= mid_q_q;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.master_en = master_en_q;
  assign bus.slave_en  = slave_en_q;
  assign bus.mid_q     = mid_q_q;
  assign bus.q         = q_q;
  assign bus.qbar      = ~q_q;
  assign state_o       = state_q;

endmodule

// File: doc/ms_ff_sequencer.md
Name: ms_ff_sequencer

Overview:
- Two-phase sequencer for a WIDTH-bit master-slave storage stage, built on the same master (mid_q) and slave (q) structure as the ms_sr_flip_flop circuit.
- Opens the master latch, waits a non-overlap gap, opens the slave latch, waits a second gap, then acknowledges the requester.
- Contains the master and slave storage as clocked registers and exports the latch enables so the phase timing can be observed.
- Sits between a single requester and the storage stage.

Parameters:
WIDTH, 1, data width of d, mid_q, q and qbar
MASTER_CYC, 2, cycles master_en is held high (must be >= 1)
SLAVE_CYC, 2, cycles slave_en is held high (must be >= 1)
DEAD_CYC, 1, non-overlap cycles between phases, both enables low (0 means the gap is skipped)
CNT_W, 4, phase counter width; must hold max(MASTER_CYC, SLAVE_CYC, DEAD_CYC)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req  input  1  start request, level-sensitive, sampled in IDLE
d  input  WIDTH  data into the master stage
ack  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
master_en  output  1  high only in state MASTER
slave_en  output  1  high only in state SLAVE
mid_q  output  WIDTH  master stage contents
q  output  WIDTH  slave stage contents
qbar  output  WIDTH  always ~q

Behaviour:
- Reset (rst_n=0, takes effect asynchronously):
  - state=IDLE and counter=0.
  - ack, busy, master_en, slave_en = 0.
  - mid_q = 0 and q = 0, so qbar = all ones.
- Reset asserted mid-operation aborts the cycle immediately. No ack is issued for the aborted request.
- States: IDLE, MASTER, GAP1, SLAVE, GAP2, DONE. All outputs are registered and decoded from state; there is no combinational path from req to the outputs.
- IDLE: if req=1 at an edge, go to MASTER with counter=0. Otherwise stay.
- MASTER:
  - At every edge in this state, mid_q <= d.
  - When counter = MASTER_CYC-1, go to GAP1 (or to SLAVE if DEAD_CYC=0) and clear the counter; otherwise counter increments.
- GAP1:
  - No storage updates.
  - When counter = DEAD_CYC-1, go to SLAVE and clear the counter.
- SLAVE:
  - At every edge in this state, q <= mid_q.
  - When counter = SLAVE_CYC-1, go to GAP2 (or to DONE if DEAD_CYC=0) and clear the counter.
- GAP2: when counter = DEAD_CYC-1, go to DONE.
- DONE: ack=1 for exactly one cycle, then IDLE unconditionally.
- Latency: ack is high in the cycle after the edge that falls MASTER_CYC + SLAVE_CYC + 2*DEAD_CYC edges after the edge that sampled req. With defaults this is 6 edges.
- Captured value: mid_q holds d sampled at the last MASTER edge.
- q never changes outside SLAVE. mid_q never changes outside MASTER.
- Non-overlap: master_en and slave_en are never high in the same cycle, for any parameter set.
- Handshake:
  - req is ignored while busy=1; dropping req mid-cycle does not abort.
  - If req is still high in the IDLE cycle after DONE, a new sequence starts. Minimum spacing between acks is sequence latency + 2 cycles.
- Counter: resets to 0 on every state change and never wraps inside a phase.

Test Plan:
1. Reset mid-SLAVE: defaults, WIDTH=1, d=1, req pulse, rst_n=0 during the SLAVE phase -> all outputs return at once to reset values (q=0, qbar=1, mid_q=0), state is IDLE, and no ack follows.
2. Basic capture: defaults, WIDTH=4, d=4'hA, req pulsed for 1 cycle -> master_en high for 2 cycles, 1 low cycle, slave_en high for 2 cycles, 1 low cycle, then ack for 1 cycle; ack appears 6 edges after the req sample; q=4'hA, qbar=4'h5.
3. Master sampling: d=4'h3 on the first MASTER edge and 4'hC on the second -> mid_q=4'hC, and q=4'hC after SLAVE; a change of d during GAP1/SLAVE/GAP2 leaves mid_q and q unchanged.
4. DEAD_CYC=0, MASTER_CYC=1, SLAVE_CYC=1 -> master_en and slave_en occupy consecutive cycles and never overlap; ack appears 2 edges after the req sample.
5. req held high continuously -> back-to-back sequences with acks spaced exactly 8 cycles apart (defaults); busy is low for 1 cycle between them.
6. req dropped during the first MASTER cycle -> the sequence completes and ack is issued.
